jesd204_soft_pcs_tx: RTL and testbench
======================================

Name: jesd204_soft_pcs_tx

Overview:
Soft transmit PCS for JESD204B links on transceivers without a hard 8b10b encoder. It takes per-lane octets plus K-flags from the link layer and 8b10b-encodes them with a running-disparity chain across the symbols of each beat. It emits 10-bit symbols per lane toward the PHY. It also provides a built-in test-pattern override for PHY bring-up.

Parameters:
NUM_LANES, 1, number of lanes (1..32).
DATA_PATH_WIDTH, 4, symbols per lane per clk (2, 4 or 8).
REGISTER_INPUTS, 0, 0: char/charisk/test_mode used directly; 1: one extra input register stage.
INVERT_OUTPUTS, 0, 1: every output symbol bit inverted after encoding (board-level P/N swap).

Ports:
clk  input  1  PCS clock (lane rate / (10*DATA_PATH_WIDTH)).
reset  input  1  reset, synchronous, active-high; clock clk.
test_mode  input  2  0: normal; 1: all symbols K28.5; 2: all symbols D21.5; 3: treated as 0.
char  input  NUM_LANES*DATA_PATH_WIDTH*8  octets; symbol j = lane*DPW+i at [j*8+:8]; i=0 transmitted first.
charisk  input  NUM_LANES*DATA_PATH_WIDTH  1 = symbol j is a control character.
data  output  NUM_LANES*DATA_PATH_WIDTH*10  encoded symbols, registered; symbol j at [j*10+:10], bit 0 = 'a', bit 9 = 'j'.
invalid_k  output  NUM_LANES*DATA_PATH_WIDTH  registered, aligned with data; 1 = charisk set on a non-legal K code.

Behaviour:
- Reset: data <= 0, invalid_k <= 0. Every lane's running disparity <= RD- (0). Any input register stage is cleared to 0. Reset mid-stream overrides all activity on that edge; the first post-reset symbol is encoded from RD-.
- Latency: 1 + REGISTER_INPUTS clk from char/charisk/test_mode to data/invalid_k.
- Encoding: standard IEEE 802.3 8b10b. The 5b/6b sub-block uses RD at block entry. The 3b/4b sub-block uses RD after the 6b sub-block. This includes the D.x.7 alternate encodings (A7 when RD- and x in {17,18,20}, or RD+ and x in {11,13,14}).
- Disparity chain per lane: symbol 0 uses the lane's registered RD. Symbol i+1 uses the RD out of symbol i. The RD out of symbol DPW-1 is registered for the next beat. Lanes are independent.
- Legal K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
- Illegal K code (charisk=1, any other octet): encoded as the D code of the same octet, RD updated accordingly, invalid_k=1 for that symbol. No other side effect.
- test_mode 1: all lanes, all symbols encode K28.5 with charisk forced to 1. RD propagates normally, so the output alternates 0x17C/0x283.
- test_mode 2: all symbols encode D21.5 (0xB5, charisk=0). The code is neutral, so the output is 0x155 every symbol and RD is unchanged.
- test_mode changes: take effect on the beat boundary; RD continues from the last encoded symbol with no reset or glitch symbol.
- Inversion: INVERT_OUTPUTS applies after encoding and does not affect RD tracking or invalid_k.
- charisk=1 in test_mode 2: ignored; invalid_k=0 in either test mode.

Test Plan:
- Reset, DPW=4, 1 lane, test_mode=1 → data symbols 0..3 = 0x17C, 0x283, 0x17C, 0x283 one clk after reset release (REGISTER_INPUTS=0). The next beat repeats 0x17C first.
- Normal mode, char=0x00 all symbols, charisk=0 from RD- → every symbol 0x0B9; RD stays -. Then one K28.5 at i=0 → 0x17C; the following D0.0 → 0x346 (RD+).
- test_mode=2 → all symbols 0x155 regardless of char; switching back to mode 0 with char=0xBC, charisk=1 → 0x17C if RD- held.
- charisk=1, char=0x00 (illegal K) → symbol encodes as D0.0 (0x0B9 at RD-), invalid_k=1 for that symbol only, aligned with data. Neighbours are unaffected.
- NUM_LANES=2, lane 0 K28.5 stream, lane 1 D0.0 stream → lane 0 alternates, lane 1 constant 0x0B9. This proves independent RD.
- Assert reset mid-stream while lane RD is + → next output encodes from RD- (K28.5 → 0x17C). INVERT_OUTPUTS=1 build → same scenarios produce the bitwise complement (0x283 for the first K28.5), with invalid_k unchanged. REGISTER_INPUTS=1 build → latency 2 clk.

Source files
------------

// File: rtl/jesd204_soft_pcs_tx.sv
// Soft JESD204B transmit PCS: per-lane 8b10b encoding with a running-disparity
// chain across the symbols of each beat, plus a K28.5 / D21.5 test-pattern override.
module jesd204_soft_pcs_tx #(
  parameter int unsigned NUM_LANES       = 1,
  parameter int unsigned DATA_PATH_WIDTH = 4,
  parameter int unsigned REGISTER_INPUTS = 0,
  parameter int unsigned INVERT_OUTPUTS  = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [1:0]                              test_mode,
  input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0]  char,
  input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0]    charisk,
  output logic [NUM_LANES*DATA_PATH_WIDTH*10-1:0] data,
  output logic [NUM_LANES*DATA_PATH_WIDTH-1:0]    invalid_k
);

  localparam int unsigned NUM_SYMS = NUM_LANES * DATA_PATH_WIDTH;

  // 5b/6b codes in RD- form, written abcdei with 'a' as the msb
  function automatic logic [5:0] d6_rdm(input logic [4:0] x);
    logic [5:0] s;
    case (x)
      5'd0:  s = 6'b100111;  5'd1:  s = 6'b011101;  5'd2:  s = 6'b101101;
      5'd3:  s = 6'b110001;  5'd4:  s = 6'b110101;  5'd5:  s = 6'b101001;
      5'd6:  s = 6'b011001;  5'd7:  s = 6'b111000;  5'd8:  s = 6'b111001;
      5'd9:  s = 6'b100101;  5'd10: s = 6'b010101;  5'd11: s = 6'b110100;
      5'd12: s = 6'b001101;  5'd13: s = 6'b101100;  5'd14: s = 6'b011100;
      5'd15: s = 6'b010111;  5'd16: s = 6'b011011;  5'd17: s = 6'b100011;
      5'd18: s = 6'b010011;  5'd19: s = 6'b110010;  5'd20: s = 6'b001011;
      5'd21: s = 6'b101010;  5'd22: s = 6'b011010;  5'd23: s = 6'b111010;
      5'd24: s = 6'b110011;  5'd25: s = 6'b100110;  5'd26: s = 6'b010110;
      5'd27: s = 6'b110110;  5'd28: s = 6'b001110;  5'd29: s = 6'b101110;
      5'd30: s = 6'b011110;  default: s = 6'b101011;
    endcase
    return s;
  endfunction

  // 3b/4b codes in RD- form (primary D.x.7), written fghj with 'f' as the msb
  function automatic logic [3:0] d4_rdm(input logic [2:0] y);
    logic [3:0] f;
    case (y)
      3'd0: f = 4'b1011;  3'd1: f = 4'b1001;  3'd2: f = 4'b0101;  3'd3: f = 4'b1100;
      3'd4: f = 4'b1101;  3'd5: f = 4'b1010;  3'd6: f = 4'b0110;  default: f = 4'b1110;
    endcase
    return f;
  endfunction

  // Returns {rd_out, legal_k, code} with code bit 0 = 'a'
  function automatic logic [11:0] encode(input logic [7:0] c, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       legal_k;
    logic       alt7;
    logic       rd6;
    logic       rd4;
    logic [5:0] s;
    logic [3:0] f;
    logic [9:0] lit;
    logic [9:0] code;
    x = c[4:0];
    y = c[7:5];
    legal_k = k && ((x == 5'd28) || ((y == 3'd7) &&
              ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30))));
    s = (legal_k && (x == 5'd28)) ? 6'b001111 : d6_rdm(x);
    if (rd_in && (($countones(s) != 3) || (x == 5'd7))) s = ~s;
    rd6 = ($countones(s) == 3) ? rd_in : ($countones(s) > 3);
    alt7 = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
           ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    // K codes take the complemented neutral 4b forms and always the alternate .7
    if (legal_k) begin
      case (y)
        3'd1, 3'd2, 3'd5, 3'd6: f = ~d4_rdm(y);
        3'd7:                   f = 4'b0111;
        default:                f = d4_rdm(y);
      endcase
    end else if ((y == 3'd7) && alt7) begin
      f = 4'b0111;
    end else begin
      f = d4_rdm(y);
    end
    if (rd6 && (legal_k || ($countones(f) != 2) || (y == 3'd3))) f = ~f;
    rd4 = ($countones(f) == 2) ? rd6 : ($countones(f) > 2);
    lit = {s, f};
    for (int b = 0; b < 10; b++) code[b] = lit[9-b];
    return {rd4, legal_k, code};
  endfunction

  logic [1:0]            test_mode_s;
  logic [NUM_SYMS*8-1:0] char_s;
  logic [NUM_SYMS-1:0]   charisk_s;

  generate
    if (REGISTER_INPUTS != 0) begin : g_in_reg
      logic [1:0]            test_mode_in_d, test_mode_in_q;
      logic [NUM_SYMS*8-1:0] char_in_d, char_in_q;
      logic [NUM_SYMS-1:0]   charisk_in_d, charisk_in_q;

      always_comb begin
        test_mode_in_d = test_mode;
        char_in_d      = char;
        charisk_in_d   = charisk;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          test_mode_in_q <= '0;
          char_in_q      <= '0;
          charisk_in_q   <= '0;
        end else begin
          test_mode_in_q <= test_mode_in_d;
          char_in_q      <= char_in_d;
          charisk_in_q   <= charisk_in_d;
        end
      end

      assign test_mode_s = test_mode_in_q;
      assign char_s      = char_in_q;
      assign charisk_s   = charisk_in_q;
    end else begin : g_in_direct
      assign test_mode_s = test_mode;
      assign char_s      = char;
      assign charisk_s   = charisk;
    end
  endgenerate

  logic [NUM_SYMS*10-1:0] data_d, data_q;
  logic [NUM_SYMS-1:0]    invalid_k_d, invalid_k_q;
  logic [NUM_LANES-1:0]   rd_d, rd_q;
  logic                   rd;
  logic [7:0]             sym_c;
  logic                   sym_k;
  logic [11:0]            enc;
  int unsigned            j;

  // Disparity chain: each symbol starts from the RD left by the previous one
  always_comb begin
    data_d      = '0;
    invalid_k_d = '0;
    rd_d        = rd_q;
    rd          = 1'b0;
    sym_c       = '0;
    sym_k       = 1'b0;
    enc         = '0;
    j           = 0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      rd = rd_q[l];
      for (int unsigned i = 0; i < DATA_PATH_WIDTH; i++) begin
        j = l * DATA_PATH_WIDTH + i;
        case (test_mode_s)
          2'd1: begin sym_c = 8'hBC; sym_k = 1'b1; end
          2'd2: begin sym_c = 8'hB5; sym_k = 1'b0; end
          default: begin sym_c = char_s[j*8 +: 8]; sym_k = charisk_s[j]; end
        endcase
        enc = encode(sym_c, sym_k, rd);
        data_d[j*10 +: 10] = (INVERT_OUTPUTS != 0) ? ~enc[9:0] : enc[9:0];
        invalid_k_d[j]     = sym_k && !enc[10];
        rd                 = enc[11];
      end
      rd_d[l] = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q      <= '0;
      invalid_k_q <= '0;
      rd_q        <= '0;
    end else begin
      data_q      <= data_d;
      invalid_k_q <= invalid_k_d;
      rd_q        <= rd_d;
    end
  end

  assign data      = data_q;
  assign invalid_k = invalid_k_q;

endmodule

// File: tb/tb_jesd204_soft_pcs_tx.sv
// Bench for jesd204_soft_pcs_tx: two builds (2 lanes direct; 1 lane, DPW=2, input
// register + inverted outputs) checked against an 8b10b reference model.
module tb_jesd204_soft_pcs_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  tm;
  logic [63:0] a_char;
  logic [7:0]  a_k;
  logic [79:0] a_data;
  logic [7:0]  a_ik;
  logic [19:0] b_data;
  logic [1:0]  b_ik;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [39:0] K4   = {10'h283, 10'h17C, 10'h283, 10'h17C};
  localparam logic [39:0] D0_4 = {4{10'h0B9}};

  always #5 clk = ~clk;

  jesd204_soft_pcs_tx #(.NUM_LANES(2), .DATA_PATH_WIDTH(4), .REGISTER_INPUTS(0), .INVERT_OUTPUTS(0)) dut_a (
    .clk(clk), .reset(reset), .test_mode(tm), .char(a_char), .charisk(a_k),
    .data(a_data), .invalid_k(a_ik));

  jesd204_soft_pcs_tx #(.NUM_LANES(1), .DATA_PATH_WIDTH(2), .REGISTER_INPUTS(1), .INVERT_OUTPUTS(1)) dut_b (
    .clk(clk), .reset(reset), .test_mode(tm), .char(a_char[15:0]), .charisk(a_k[1:0]),
    .data(b_data), .invalid_k(b_ik));

  // Reference tables: 'a' (or 'f') is the msb of each literal, RD- forms
  logic [5:0] six_tbl [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] four_tbl [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [7:0] k_oct [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                             8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [9:0] k_tbl [12] = '{
    10'b001111_0100, 10'b001111_1001, 10'b001111_0101, 10'b001111_0011,
    10'b001111_0010, 10'b001111_1010, 10'b001111_0110, 10'b001111_1000,
    10'b111010_1000, 10'b110110_1000, 10'b101110_1000, 10'b011110_1000};

  function automatic int ones(input logic [9:0] v);
    int n = 0;
    for (int b = 0; b < 10; b++) n += int'(v[b]);
    return n;
  endfunction

  // Returns {rd_out, invalid_k, code (bit 0 = 'a')}
  function automatic logic [11:0] model_sym(input logic [7:0] c, input logic k, input logic rd);
    logic [9:0] lit;
    logic [9:0] code;
    logic [5:0] s;
    logic [3:0] f;
    logic       rd_mid;
    logic       found;
    logic       rd_out;
    int         x;
    int         y;
    x = int'(c[4:0]);
    y = int'(c[7:5]);
    found = 1'b0;
    lit = '0;
    for (int n = 0; n < 12; n++)
      if (k && (c == k_oct[n])) begin
        lit = rd ? ~k_tbl[n] : k_tbl[n];
        found = 1'b1;
      end
    if (!found) begin
      // pick the sub-block variant whose disparity pulls RD back toward balance
      s = six_tbl[x];
      if (!rd && ones({4'b0, s}) < 3) s = ~s;
      if (rd && ones({4'b0, s}) > 3) s = ~s;
      if (rd && x == 7) s = ~s;
      rd_mid = (ones({4'b0, s}) == 3) ? rd : (ones({4'b0, s}) > 3);
      f = four_tbl[y];
      if (y == 7 && ((!rd_mid && (x == 17 || x == 18 || x == 20)) ||
                     (rd_mid && (x == 11 || x == 13 || x == 14)))) f = 4'b0111;
      if (!rd_mid && ones({6'b0, f}) < 2) f = ~f;
      if (rd_mid && ones({6'b0, f}) > 2) f = ~f;
      if (rd_mid && y == 3) f = ~f;
      lit = {s, f};
    end
    rd_out = (ones(lit) == 5) ? rd : (ones(lit) > 5);
    for (int b = 0; b < 10; b++) code[b] = lit[9-b];
    return {rd_out, k && !found, code};
  endfunction

  function automatic void model_beat(input logic [63:0] ch, input logic [7:0] kk, input logic [1:0] mode,
                                     input int nl, input int dpw, input bit inv, input logic [1:0] rd_in,
                                     output logic [79:0] d, output logic [7:0] ik, output logic [1:0] rd_out);
    logic [11:0] r;
    logic [7:0]  c;
    logic        k;
    d = '0;
    ik = '0;
    rd_out = rd_in;
    for (int l = 0; l < nl; l++)
      for (int i = 0; i < dpw; i++) begin
        int s;
        s = l * dpw + i;
        if (mode == 2'd1) begin c = 8'hBC; k = 1'b1; end
        else if (mode == 2'd2) begin c = 8'hB5; k = 1'b0; end
        else begin c = ch[s*8 +: 8]; k = kk[s]; end
        r = model_sym(c, k, rd_out[l]);
        d[s*10 +: 10] = inv ? ~r[9:0] : r[9:0];
        ik[s] = r[10];
        rd_out[l] = r[11];
      end
  endfunction

  logic [1:0]  rd_a, rd_b;
  logic [79:0] exp_a_d;
  logic [7:0]  exp_a_ik;
  logic [19:0] exp_b_d;
  logic [1:0]  exp_b_ik;
  logic [15:0] b_reg_c;
  logic [1:0]  b_reg_k;
  logic [1:0]  b_reg_m;

  // Advance one clock, updating the model from the inputs sampled at the edge
  task automatic tick();
    logic [79:0] d;
    logic [7:0]  ik;
    logic [1:0]  rdn;
    @(posedge clk);
    if (reset) begin
      exp_a_d = '0; exp_a_ik = '0; rd_a = '0;
      exp_b_d = '0; exp_b_ik = '0; rd_b = '0;
      b_reg_c = '0; b_reg_k = '0; b_reg_m = '0;
    end else begin
      model_beat(a_char, a_k, tm, 2, 4, 1'b0, rd_a, d, ik, rdn);
      exp_a_d = d; exp_a_ik = ik; rd_a = rdn;
      model_beat({48'b0, b_reg_c}, {6'b0, b_reg_k}, b_reg_m, 1, 2, 1'b1, rd_b, d, ik, rdn);
      exp_b_d = d[19:0]; exp_b_ik = ik[1:0]; rd_b = rdn;
      b_reg_c = a_char[15:0]; b_reg_k = a_k[1:0]; b_reg_m = tm;
    end
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tm = 2'd1; a_char = {$urandom, $urandom}; a_k = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (a_data !== 80'h0) begin n_fail++; $display("FAIL reset_a_data: got %h expected 0", a_data); end
      n_checks++; if (a_ik !== 8'h0) begin n_fail++; $display("FAIL reset_a_ik: got %h expected 0", a_ik); end
      n_checks++; if (b_data !== 20'h0) begin n_fail++; $display("FAIL reset_b_data: got %h expected 0", b_data); end
    end
  endtask

  task automatic test_k28_pattern();
    reset = 1'b0; tm = 2'd1;
    tick();
    n_checks++; if (a_data !== {K4, K4}) begin n_fail++; $display("FAIL k28_first_beat: got %h expected %h", a_data, {K4, K4}); end
    n_checks++; if (a_ik !== 8'h0) begin n_fail++; $display("FAIL k28_ik: got %h expected 0", a_ik); end
    n_checks++; if (b_data !== exp_b_d) begin n_fail++; $display("FAIL k28_b_lat1: got %h expected %h", b_data, exp_b_d); end
    tick();
    n_checks++; if (a_data !== {K4, K4}) begin n_fail++; $display("FAIL k28_second_beat: got %h expected %h", a_data, {K4, K4}); end
    n_checks++; if (b_data !== {10'h17C, 10'h283}) begin n_fail++; $display("FAIL k28_b_inverted: got %h expected %h", b_data, {10'h17C, 10'h283}); end
    n_checks++; if (b_ik !== 2'b00) begin n_fail++; $display("FAIL k28_b_ik: got %b expected 00", b_ik); end
  endtask

  task automatic test_normal_d00();
    reset_pulse();
    tm = 2'd0; a_char = '0; a_k = '0;
    tick();
    n_checks++; if (a_data !== {D0_4, D0_4}) begin n_fail++; $display("FAIL d00_stream: got %h expected %h", a_data, {D0_4, D0_4}); end
    a_char[7:0] = 8'hBC; a_k = 8'h01;
    tick();
    n_checks++; if (a_data[9:0] !== 10'h17C) begin n_fail++; $display("FAIL d00_k28_sym0: got %h expected 17C", a_data[9:0]); end
    n_checks++; if (a_data[19:10] !== 10'h346) begin n_fail++; $display("FAIL d00_after_k_rdp: got %h expected 346", a_data[19:10]); end
    n_checks++; if (a_data !== exp_a_d) begin n_fail++; $display("FAIL d00_model: got %h expected %h", a_data, exp_a_d); end
  endtask

  task automatic test_mode2();
    reset_pulse();
    tm = 2'd2;
    for (int c = 0; c < 4; c++) begin
      a_char = {$urandom, $urandom}; a_k = 8'($urandom);
      tick();
      n_checks++; if (a_data !== {8{10'h155}}) begin n_fail++; $display("FAIL mode2_data: got %h expected all 155", a_data); end
      n_checks++; if (a_ik !== 8'h0) begin n_fail++; $display("FAIL mode2_ik: got %h expected 0", a_ik); end
    end
    tm = 2'd0; a_char = {8{8'hBC}}; a_k = 8'hFF;
    tick();
    n_checks++; if (a_data !== {K4, K4}) begin n_fail++; $display("FAIL mode2_to_k28: got %h expected %h", a_data, {K4, K4}); end
  endtask

  task automatic test_illegal_k();
    reset_pulse();
    tm = 2'd0; a_char = '0; a_k = 8'h02;
    tick();
    n_checks++; if (a_data !== {D0_4, D0_4}) begin n_fail++; $display("FAIL illk_data: got %h expected %h", a_data, {D0_4, D0_4}); end
    n_checks++; if (a_ik !== 8'h02) begin n_fail++; $display("FAIL illk_ik: got %h expected 02", a_ik); end
    a_k = 8'h00;
    tick();
    n_checks++; if (a_ik !== 8'h00) begin n_fail++; $display("FAIL illk_next_beat: got %h expected 00", a_ik); end
    n_checks++; if (b_ik !== 2'b10) begin n_fail++; $display("FAIL illk_b_ik: got %b expected 10", b_ik); end
    n_checks++; if (b_data !== {2{10'h346}}) begin n_fail++; $display("FAIL illk_b_data: got %h expected %h", b_data, {2{10'h346}}); end
  endtask

  task automatic test_lanes();
    reset_pulse();
    tm = 2'd0; a_char = {32'h0, {4{8'hBC}}}; a_k = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (a_data[39:0] !== K4) begin n_fail++; $display("FAIL lanes_l0: got %h expected %h", a_data[39:0], K4); end
      n_checks++; if (a_data[79:40] !== D0_4) begin n_fail++; $display("FAIL lanes_l1: got %h expected %h", a_data[79:40], D0_4); end
    end
  endtask

  task automatic test_reset_midstream();
    reset_pulse();
    tm = 2'd0; a_char = {56'h0, 8'hBC}; a_k = 8'h01;
    tick();
    n_checks++; if (a_data !== exp_a_d) begin n_fail++; $display("FAIL mid_pre: got %h expected %h", a_data, exp_a_d); end
    a_char = {8{8'hBC}}; a_k = 8'hFF; reset = 1'b1;
    tick();
    n_checks++; if (a_data !== 80'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h expected 0", a_data); end
    reset = 1'b0;
    tick();
    n_checks++; if (a_data !== {K4, K4}) begin n_fail++; $display("FAIL mid_post_rdm: got %h expected %h", a_data, {K4, K4}); end
    tick();
    n_checks++; if (b_data !== {10'h17C, 10'h283}) begin n_fail++; $display("FAIL mid_b_rdm: got %h expected %h", b_data, {10'h17C, 10'h283}); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 9))
        0: tm = 2'd1;
        1: tm = 2'd2;
        2: tm = 2'd3;
        default: tm = 2'd0;
      endcase
      for (int s = 0; s < 8; s++) begin
        case ($urandom_range(0, 7))
          0, 1: begin a_char[s*8 +: 8] = k_oct[$urandom_range(0, 11)]; a_k[s] = 1'b1; end
          2: begin a_char[s*8 +: 8] = 8'($urandom); a_k[s] = 1'b1; end
          default: begin a_char[s*8 +: 8] = 8'($urandom); a_k[s] = 1'b0; end
        endcase
      end
      tick();
      n_checks++; if (a_data !== exp_a_d) begin n_fail++; $display("FAIL rand_a_data beat %0d: got %h expected %h", c, a_data, exp_a_d); end
      n_checks++; if (a_ik !== exp_a_ik) begin n_fail++; $display("FAIL rand_a_ik beat %0d: got %h expected %h", c, a_ik, exp_a_ik); end
      n_checks++; if (b_data !== exp_b_d) begin n_fail++; $display("FAIL rand_b_data beat %0d: got %h expected %h", c, b_data, exp_b_d); end
      n_checks++; if (b_ik !== exp_b_ik) begin n_fail++; $display("FAIL rand_b_ik beat %0d: got %b expected %b", c, b_ik, exp_b_ik); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tm = 2'd0; a_char = '0; a_k = '0;
    test_reset();
    test_k28_pattern();
    test_normal_d00();
    test_mode2();
    test_illegal_k();
    test_lanes();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
